// File: rtl/comp_seq_slicer.sv
// Sequential WIDTH-bit magnitude comparator: walks 2-bit slices MSB-first, one per cycle.
// Define COMP_SIGNED_EN for two's-complement ordering (operand MSB inverted before compare).
module comp_seq_slicer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             g,
   output logic             l,
   output logic             e,
   output logic             busy
);

   localparam int unsigned NS = WIDTH / 2;
   localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             g_q, g_d, l_q, l_d, e_q, e_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] a_eff, b_eff;
   logic [1:0]       sa, sb;

`ifdef COMP_SIGNED_EN
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign a_eff = {~a_q[WIDTH-1], a_q[WIDTH-2:0]};
   assign b_eff = {~b_q[WIDTH-1], b_q[WIDTH-2:0]};
`else
   assign a_eff = a_q;
   assign b_eff = b_q;
`endif

   assign sa = 2'(a_eff >> {idx_q, 1'b0});
   assign sb = 2'(b_eff >> {idx_q, 1'b0});

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         g_q         <= 1'b0;
         l_q         <= 1'b0;
         e_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         g_q         <= g_d;
         l_q         <= l_d;
         e_q         <= e_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid) state_d = S_RUN;
         S_RUN:  if ((sa != sb) || (idx_q == '0)) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; the result is only written on the RUN->DONE step
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      g_d         = g_q;
      l_d         = l_q;
      e_d         = e_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d   = a;
               b_d   = b;
               idx_d = IW'(NS - 1);
               g_d   = 1'b0;
               l_d   = 1'b0;
               e_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (sa > sb) begin
               g_d         = 1'b1;
               out_valid_d = 1'b1;
            end else if (sa < sb) begin
               l_d         = 1'b1;
               out_valid_d = 1'b1;
            end else if (idx_q == '0) begin
               e_d         = 1'b1;
               out_valid_d = 1'b1;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               g_d         = 1'b0;
               l_d         = 1'b0;
               e_d         = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from registered state
   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      busy      = (state_q != S_IDLE);
      out_valid = out_valid_q;
      g         = g_q;
      l         = l_q;
      e         = e_q;
   end

endmodule

// File: tb/tb_comp_seq_slicer.sv
// Directed bench for comp_seq_slicer (WIDTH=8) with an expected-result queue.
module tb_comp_seq_slicer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NS    = WIDTH / 2;

   typedef struct packed {
      logic g;
      logic l;
      logic e;
      int   k;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] a, b;
   logic             g, l, e, busy;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   comp_seq_slicer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .g(g), .l(l), .e(e), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t r;
      logic found;
      r.k   = NS;
      found = 1'b0;
      for (int s = NS - 1; s >= 0; s--) begin
         if (!found && (x[2*s +: 2] != y[2*s +: 2])) begin
            r.k   = NS - s;
            found = 1'b1;
         end
      end
`ifdef COMP_SIGNED_EN
      r.g = $signed(x) > $signed(y);
      r.l = $signed(x) < $signed(y);
`else
      r.g = x > y;
      r.l = x < y;
`endif
      r.e = (x == y);
      return r;
   endfunction

   // Present a pair at the current negedge, push the expectation, return just after the accept edge.
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      a        = x;
      b        = y;
      in_valid = 1'b1;
      exp_q.push_back(model(x, y));
      #1;
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Count RUN cycles until out_valid, then compare against the popped expectation.
   task automatic wait_result(input string tag);
      exp_t x;
      int   cyc;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!out_valid && cyc < 20);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         x = exp_q.pop_front();
         check({tag, "_latency"}, 32'(cyc), 32'(x.k));
         check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_gle"}, 32'({g, l, e}), 32'({x.g, x.l, x.e}));
         check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      end
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_cleared"}, 32'({out_valid, g, l, e, busy}), 32'd0);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #2;
      check("reset_outputs", 32'({out_valid, g, l, e, busy}), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Early, late and full-equality decisions
      send(8'hA5, 8'h35); wait_result("early");    release_result("early");
      send(8'h12, 8'h13); wait_result("late");     release_result("late");
      send(8'h5A, 8'h5A); wait_result("equal");    release_result("equal");
      send(8'h80, 8'h01); wait_result("signed");   release_result("signed");

      // Backpressure with a new pair already waiting
      send(8'h40, 8'h80);
      wait_result("bp");
      @(negedge clk);
      a        = 8'hFF;
      b        = 8'h00;
      in_valid = 1'b1;
      exp_q.push_back(model(8'hFF, 8'h00));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_gle", 32'({g, l, e}), 32'b010);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_idle_cycle", 32'({out_valid, busy, in_ready}), 32'b001);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_new_accept", 32'(busy), 32'd1);
      wait_result("bp_next");
      // Consumer already ready on the first DONE cycle
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_next_cleared", 32'({out_valid, busy}), 32'd0);
      @(negedge clk);

      // Reset during the second RUN cycle discards the pending result
      send(8'h01, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_run_outputs", 32'({out_valid, g, l, e, busy}), 32'd0);
      check("rst_mid_run_in_ready", 32'(in_ready), 32'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("rst_no_result", 32'({out_valid, busy}), 32'd0);
      end
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // A few random pairs
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom);
         rb = (i % 3 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
         send(ra, rb);
         wait_result("rand");
         release_result("rand");
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
